// File: rtl/toggle_cover_drain_if.sv
// Index stream from the coverage collector to its sink.
// A transfer happens on a clock edge where out_valid && out_ready; out_index is held while out_valid && !out_ready.
interface toggle_cover_drain_if #(
   parameter int INDEX_W = 64
);
   logic               out_valid;
   logic               out_ready;
   logic [INDEX_W-1:0] out_index;

   modport master (output out_valid, output out_index, input out_ready);
   modport slave  (input out_valid, input out_index, output out_ready);
endinterface

// File: rtl/toggle_cover_drain.sv
// Sticky toggle-coverage collector that drains first hits as global cover indices, round-robin, one per cycle.
// Optional macro TOGGLE_DRAIN_CLEAR_EN adds a synchronous `clear` input that starts a new coverage epoch.
module toggle_cover_drain #(
   parameter int              WIDTH       = 32,
   parameter longint unsigned COVER_INDEX = 0,
   parameter int              INDEX_W     = 64,
   localparam int             CNT_W       = $clog2(WIDTH + 1),
   localparam int             PTR_W       = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [WIDTH-1:0]     valid,
`ifdef TOGGLE_DRAIN_CLEAR_EN
   input  logic                 clear,
`endif
   toggle_cover_drain_if.master out,
   output logic [CNT_W-1:0]     covered_count,
   output logic                 all_covered,
   output logic                 pending
);

   logic [WIDTH-1:0]   covered_q, covered_d;
   logic [WIDTH-1:0]   pend_q, pend_d;
   logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic               out_valid_q, out_valid_d;
   logic [INDEX_W-1:0] out_index_q, out_index_d;
   logic [CNT_W-1:0]   covered_count_q, covered_count_d;

   logic               clr;
   logic [WIDTH-1:0]   new_hits;
   logic [WIDTH-1:0]   grant;
   logic [WIDTH-1:0]   count_src;
   logic [CNT_W-1:0]   hit_cnt;
   logic               load;
   logic               found;
   logic               take;
   logic [PTR_W-1:0]   sel;
   logic [PTR_W:0]     idx_wide;
   logic [PTR_W-1:0]   idx;

`ifdef TOGGLE_DRAIN_CLEAR_EN
   assign clr = clear;
`else
   assign clr = 1'b0;
`endif

   assign new_hits = valid & ~covered_q;
   assign load     = !out_valid_q || out.out_ready;

   // Wrapping search from rr_ptr over the registered pend vector only.
   always_comb begin
      found    = 1'b0;
      sel      = '0;
      idx_wide = '0;
      idx      = '0;
      for (int k = 0; k < WIDTH; k++) begin
         idx_wide = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
         if (idx_wide >= (PTR_W+1)'(WIDTH)) idx_wide = idx_wide - (PTR_W+1)'(WIDTH);
         idx = idx_wide[PTR_W-1:0];
         if (!found && pend_q[idx]) begin
            found = 1'b1;
            sel   = idx;
         end
      end
   end

   // A clear cycle starts a fresh epoch, so no old-epoch bit is granted in it.
   assign take = load && found && !clr;

   always_comb begin
      grant = '0;
      if (take) grant[sel] = 1'b1;
   end

   assign count_src = clr ? valid : new_hits;

   always_comb begin
      hit_cnt = '0;
      for (int k = 0; k < WIDTH; k++) begin
         hit_cnt = hit_cnt + CNT_W'(count_src[k]);
      end
   end

   always_comb begin
      covered_d       = covered_q | valid;
      pend_d          = (pend_q & ~grant) | new_hits;
      covered_count_d = covered_count_q + hit_cnt;
      rr_ptr_d        = rr_ptr_q;
      out_valid_d     = out_valid_q;
      out_index_d     = out_index_q;
      if (clr) begin
         covered_d       = valid;
         pend_d          = valid;
         covered_count_d = hit_cnt;
         rr_ptr_d        = '0;
      end
      if (load) begin
         out_valid_d = take;
         if (take) begin
            out_index_d = INDEX_W'(COVER_INDEX) + INDEX_W'(sel);
            rr_ptr_d    = (sel == PTR_W'(WIDTH - 1)) ? '0 : sel + PTR_W'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         covered_q       <= '0;
         pend_q          <= '0;
         rr_ptr_q        <= '0;
         out_valid_q     <= 1'b0;
         out_index_q     <= '0;
         covered_count_q <= '0;
      end else begin
         covered_q       <= covered_d;
         pend_q          <= pend_d;
         rr_ptr_q        <= rr_ptr_d;
         out_valid_q     <= out_valid_d;
         out_index_q     <= out_index_d;
         covered_count_q <= covered_count_d;
      end
   end

   assign out.out_valid = out_valid_q;
   assign out.out_index = out_index_q;
   assign covered_count = covered_count_q;
   assign all_covered   = (covered_count_q == CNT_W'(WIDTH));
   assign pending       = |pend_q;

endmodule

// File: doc/toggle_cover_drain.md
Name: toggle_cover_drain

Overview:
- Sticky toggle-coverage collector and report scheduler for one WIDTH-bit toggle group.
- Records first hits of each bit in the per-cycle `valid` vector.
- Queues newly covered bits and drains them as global cover indices (COVER_INDEX + bit) one per cycle over a valid/ready stream. A downstream DPI bridge or formal monitor consumes that stream.
- Sits beside the per-group toggle instrumentation, between the DUT probes and the coverage sink.

Parameters:
- WIDTH, 32, number of toggle points in the group (1..256).
- COVER_INDEX, 0, global index of bit 0 of this group.
- INDEX_W, 64, width of emitted index (matches longint sink).

Ports:
- clock  input  1  single clock, all state on posedge.
- reset  input  1  synchronous, active-high; clears all state.
- valid  input  WIDTH  per-cycle toggle hit vector; bit i high = point i toggled this cycle.
- out_valid  output  1  index available.
- out_ready  input  1  sink accepts index.
- out_index  output  INDEX_W  COVER_INDEX + bit number, zero-extended.
- covered_count  output  $clog2(WIDTH+1)  number of distinct bits covered so far.
- all_covered  output  1  covered_count == WIDTH.
- pending  output  1  at least one covered bit not yet emitted (pending register nonzero).

Behaviour:
- Reset values: out_valid=0, out_index=0, covered_count=0, all_covered=0, pending=0. Internal covered, pend, and rr_ptr registers are all 0.
- Reset has priority over every other input. Asserting reset mid-drain discards the in-flight out entry and all pend bits; nothing is re-reported after reset.
- valid is sampled every non-reset cycle.
  - new_hits = valid & ~covered.
  - covered <= covered | valid.
  - covered_count <= covered_count + popcount(new_hits), computed at full width; it cannot exceed WIDTH.
- pend register: pend <= (pend & ~grant_onehot) | new_hits.
  - A bit already in pend, or already emitted, is never re-queued. Each bit is reported at most once per epoch.
- Output register load condition: load = !out_valid | (out_valid & out_ready).
  - On load with pend != 0, select the first set bit of pend searching from rr_ptr upward, wrapping at WIDTH-1 to 0.
  - On such a load: out_index <= COVER_INDEX + sel; out_valid <= 1; pend bit sel cleared; rr_ptr <= (sel == WIDTH-1) ? 0 : sel+1.
  - On load with pend == 0: out_valid <= 0 and out_index holds its value.
- Selection uses the registered pend only, not same-cycle new_hits. Minimum latency is 2 cycles: valid[i] high in cycle t gives out_valid with index i in cycle t+2.
- Back-to-back throughput is 1 index/cycle while out_ready=1.
- While out_valid=1 and out_ready=0, out_index is stable and pend keeps accumulating. The stream holds no combinational ready->valid path.
- all_covered and pending are registered-derived: all_covered from covered_count, pending from pend != 0.
- Boundary cases:
  - WIDTH bits hit in one cycle: covered_count jumps to WIDTH in one step. Then exactly WIDTH transfers follow in round-robin order starting at rr_ptr.
  - A bit hit again in the same cycle it is granted is not re-queued.

Optional Feature:
- Macro: TOGGLE_DRAIN_CLEAR_EN.
- With the macro defined:
  - Adds input port `clear` (1 bit, synchronous, active-high), which starts a new coverage epoch.
  - On clear: covered <= valid, pend <= valid, covered_count <= popcount(valid), rr_ptr <= 0. Same-cycle hits count as the first hits of the new epoch.
  - The in-flight out entry (if out_valid) is kept until accepted.
  - Reset still overrides clear.
- Without the macro: no `clear` port; coverage is sticky until reset.

Test Plan:
- Reset then valid=0x0000_0001 for one cycle, out_ready=1, COVER_INDEX=100 -> out_valid high 2 cycles later with out_index=100 for one cycle; covered_count=1; pending=0 afterward.
- valid=0xFFFF_FFFF one cycle, out_ready=1 -> covered_count=32 next cycle, all_covered=1; 32 consecutive transfers of indices 100..131 in order, then out_valid=0.
- valid=0x0000_0005 with out_ready=0 for 10 cycles -> out_index=100 held stable, pending=1. Then out_ready=1 -> transfers 100, then 102, no duplicates.
- Repeated valid=0x0000_0008 for 20 cycles -> exactly one transfer (index 103); covered_count stays 1.
- Mid-drain reset: valid=0x0000_00FF, assert reset after 3 transfers -> out_valid=0 next cycle, covered_count=0, no further transfers. Hitting bit 0 again afterward reports index 100 again.
- TOGGLE_DRAIN_CLEAR_EN: cover 0x3, drain both, then pulse clear with valid=0x1 -> covered_count=1, one transfer of index 100. Re-hitting bit 1 reports index 101.
